fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/fetch_if.sv | 23 ++
 rtl/fetch.sv | 88 ++++++++
 tb/tb_fetch.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bundle: branch/stall controls, instruction memory port and decode-side outputs.
// The master modport is the fetch stage; the slave modport is the surrounding pipeline/memory.
interface fetch_if;
  logic        bj;
  logic [7:0]  bjadr;
  logic        stall;
  logic [7:0]  imem_adr;
  logic [15:0] imem_data;
  logic [15:0] bjinst;
  logic [7:0]  nxtadrsr;
  logic [7:0]  pc;
  logic        halted;

  modport master (
    input  bj, bjadr, stall, imem_data,
    output imem_adr, bjinst, nxtadrsr, pc, halted
  );

  modport slave (
    output bj, bjadr, stall, imem_data,
    input  imem_adr, bjinst, nxtadrsr, pc, halted
  );
endinterface

// File: rtl/fetch.sv
// Instruction fetch stage: BOOT/RUN/HALT FSM feeding one instruction per cycle to decode,
// with branch redirect, stall hold and halt-opcode detection.
module fetch #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [3:0] HALT_OP  = 4'hF
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] inst_q, inst_d;
  logic [7:0]  nxt_q, nxt_d;
  logic [7:0]  pc_inc;

  assign pc_inc = pc_q + 8'd1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    nxt_d   = nxt_q;
    unique case (state_q)
      StBoot: begin
        state_d = StRun;
        inst_d  = 16'h0000;
        nxt_d   = 8'h00;
      end
      StRun: begin
        if (bus.bj) begin
          state_d = StRun;
          pc_d    = bus.bjadr;
          inst_d  = 16'h0000;
          nxt_d   = 8'h00;
        end else if (bus.stall) begin
          state_d = StRun;
        end else if (bus.imem_data[15:12] == HALT_OP) begin
          // The halt instruction itself is swallowed; pc stays on it.
          state_d = StHalt;
          inst_d  = 16'h0000;
        end else begin
          pc_d    = pc_inc;
          inst_d  = bus.imem_data;
          nxt_d   = pc_inc;
        end
      end
      StHalt: begin
        inst_d = 16'h0000;
        if (bus.bj) begin
          state_d = StRun;
          pc_d    = bus.bjadr;
          nxt_d   = 8'h00;
        end
      end
      default: begin
        state_d = StBoot;
        pc_d    = RESET_PC;
        inst_d  = 16'h0000;
        nxt_d   = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      inst_q  <= 16'h0000;
      nxt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      nxt_q   <= nxt_d;
    end
  end

  assign bus.imem_adr = pc_q;
  assign bus.pc       = pc_q;
  assign bus.bjinst   = inst_q;
  assign bus.nxtadrsr = nxt_q;
  assign bus.halted   = (state_q == StHalt);

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: a table of per-edge vectors plus hand-written reset sequences.
module tb_fetch;

  logic clk;
  logic rst;
  fetch_if bus ();

  fetch #(
    .RESET_PC (8'h00),
    .HALT_OP  (4'hF)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] imem [256];
  assign bus.imem_data = imem[bus.imem_adr];

  typedef struct {
    logic        bj;
    logic [7:0]  bjadr;
    logic        stall;
    logic [15:0] inst;
    logic [7:0]  nxt;
    logic [7:0]  pc;
    logic        halted;
  } vec_t;

  vec_t tbl[$];
  int   n_vec;
  int   n_err;

  function automatic vec_t mk(logic bj, logic [7:0] adr, logic st, logic [15:0] inst,
                              logic [7:0] nxt, logic [7:0] pc, logic h);
    vec_t v;
    v.bj = bj; v.bjadr = adr; v.stall = st;
    v.inst = inst; v.nxt = nxt; v.pc = pc; v.halted = h;
    return v;
  endfunction

  task automatic chk(string name, logic [15:0] inst, logic [7:0] nxt, logic [7:0] pc,
                     logic h);
    n_vec++;
    if (bus.bjinst !== inst || bus.nxtadrsr !== nxt || bus.pc !== pc ||
        bus.imem_adr !== pc || bus.halted !== h) begin
      n_err++;
      $display("FAIL %s: got bjinst=%h nxtadrsr=%h pc=%h imem_adr=%h halted=%b, want %h %h %h %h %b",
               name, bus.bjinst, bus.nxtadrsr, bus.pc, bus.imem_adr, bus.halted,
               inst, nxt, pc, pc, h);
    end
  endtask

  task automatic step(logic bj, logic [7:0] adr, logic st);
    bus.bj = bj; bus.bjadr = adr; bus.stall = st;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    imem[8'h00] = 16'h1123; imem[8'h01] = 16'h2245; imem[8'h02] = 16'h3367;
    imem[8'h03] = 16'h4401; imem[8'h04] = 16'h5502; imem[8'h05] = 16'hF000;
    imem[8'h10] = 16'h6610; imem[8'h11] = 16'h7711;
    imem[8'h40] = 16'h8840; imem[8'hFF] = 16'h1001;

    // bj, bjadr, stall -> bjinst, nxtadrsr, pc, halted after the edge
    tbl.push_back(mk(1'b1, 8'h77, 1'b0, 16'h0000, 8'h00, 8'h00, 1'b0)); // BOOT ignores bj
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 16'h1123, 8'h01, 8'h01, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 16'h2245, 8'h02, 8'h02, 1'b0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1'b0, 8'h00, 1'b1, 16'h2245, 8'h02, 8'h02, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 16'h3367, 8'h03, 8'h03, 1'b0));
    tbl.push_back(mk(1'b1, 8'h40, 1'b1, 16'h0000, 8'h00, 8'h40, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 16'h8840, 8'h41, 8'h41, 1'b0));
    tbl.push_back(mk(1'b1, 8'h03, 1'b0, 16'h0000, 8'h00, 8'h03, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 16'h4401, 8'h04, 8'h04, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 16'h5502, 8'h05, 8'h05, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 16'h0000, 8'h05, 8'h05, 1'b1)); // halt opcode
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(1'b0, 8'h00, 1'(i % 2), 16'h0000, 8'h05, 8'h05, 1'b1));
    tbl.push_back(mk(1'b1, 8'h10, 1'b1, 16'h0000, 8'h00, 8'h10, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 16'h6610, 8'h11, 8'h11, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 16'h7711, 8'h12, 8'h12, 1'b0));
    tbl.push_back(mk(1'b1, 8'hFF, 1'b0, 16'h0000, 8'h00, 8'hFF, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 16'h1001, 8'h00, 8'h00, 1'b0)); // pc wrap
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 16'h1123, 8'h01, 8'h01, 1'b0));

    rst = 1'b0;
    bus.bj = 1'b0; bus.bjadr = 8'h00; bus.stall = 1'b0;
    #12;
    chk("reset_hold", 16'h0000, 8'h00, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    chk("reset_after_edge", 16'h0000, 8'h00, 8'h00, 1'b0);
    rst = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].bj, tbl[i].bjadr, tbl[i].stall);
      chk($sformatf("vec%0d", i), tbl[i].inst, tbl[i].nxt, tbl[i].pc, tbl[i].halted);
    end

    // Reset pulse between edges while halted at pc=05.
    step(1'b1, 8'h05, 1'b0);
    chk("to_05", 16'h0000, 8'h00, 8'h05, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("halt_05", 16'h0000, 8'h00, 8'h05, 1'b1);
    #2 rst = 1'b0;
    #1 chk("async_reset_in_halt", 16'h0000, 8'h00, 8'h00, 1'b0);
    #2 rst = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    chk("reboot", 16'h0000, 8'h00, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("reboot_first", 16'h1123, 8'h01, 8'h01, 1'b0);

    // Reset during stall with a pending branch, held across an edge.
    bus.stall = 1'b1; bus.bj = 1'b1; bus.bjadr = 8'h40;
    #2 rst = 1'b0;
    #1 chk("async_reset_stall", 16'h0000, 8'h00, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    chk("reset_drops_bj", 16'h0000, 8'h00, 8'h00, 1'b0);
    bus.stall = 1'b0; bus.bj = 1'b0;
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    chk("reboot2", 16'h0000, 8'h00, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("reboot2_first", 16'h1123, 8'h01, 8'h01, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("reboot2_second", 16'h2245, 8'h02, 8'h02, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
